// File: rtl/adc_emu_pkg.sv
// Shared constants for the SPI ADC emulator: word width, command channel field,
// power-on sample table and FSM state encoding.
package adc_emu_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned CH_SEL_MSB = 13;
  localparam int unsigned CH_SEL_LSB = 12;

  localparam logic [15:0] RST_SAMPLE_0 = 16'h1234;
  localparam logic [15:0] RST_SAMPLE_1 = 16'h5678;
  localparam logic [15:0] RST_SAMPLE_2 = 16'h9ABC;
  localparam logic [15:0] RST_SAMPLE_3 = 16'hDEF0;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } emu_state_t;

  // Channels beyond the first four power up as zero.
  function automatic logic [15:0] reset_sample(input int unsigned idx);
    case (idx)
      0:       return RST_SAMPLE_0;
      1:       return RST_SAMPLE_1;
      2:       return RST_SAMPLE_2;
      3:       return RST_SAMPLE_3;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer for one SPI pin, with rise/fall strobes derived from
// the synchronized value and its one-cycle-delayed copy.
module spi_in_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {SYNC_STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign dout = chain[SYNC_STAGES-1];
  assign rise = dout & ~prev;
  assign fall = ~dout & prev;

endmodule

// File: rtl/adc_spi_emulator.sv
// Synthesizable 4-channel SPI (mode 0) ADC model, oversampled on clk.
// The command captured in one frame selects the channel returned in the next.
module adc_spi_emulator
  import adc_emu_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic              ch_wr_en,
  input  logic [CH_W-1:0]   ch_wr_sel,
  input  logic [DATA_W-1:0] ch_wr_data,
  output logic              frame_done,
  output logic              frame_error,
  output logic [DATA_W-1:0] last_cmd,
  output logic [15:0]       frame_count
);

  localparam int unsigned BC_W = $clog2(DATA_W + 2);
  localparam logic [BC_W-1:0] BC_FULL = BC_W'(DATA_W);
  localparam logic [BC_W-1:0] BC_SAT  = BC_W'(DATA_W + 1);

  emu_state_t        state;
  logic [DATA_W-1:0] shift_in;
  logic [DATA_W-1:0] shift_out;
  logic [BC_W-1:0]   bit_cnt;
  logic [CH_W-1:0]   ch_ptr;
  logic [DATA_W-1:0] sample_tbl [NUM_CH];

  logic sck_s, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s;
  logic [1:0] mosi_edges_unused;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk (clk),
    .rst (rst),
    .din (spi_sck),
    .dout(sck_s),
    .rise(sck_rise),
    .fall(sck_fall)
  );

  // cs_n resets to the asserted level so a frame interrupted by reset
  // produces no fall edge; only a full rise-then-fall opens a new frame.
  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
    .clk (clk),
    .rst (rst),
    .din (spi_cs_n),
    .dout(cs_s),
    .rise(cs_rise),
    .fall(cs_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk (clk),
    .rst (rst),
    .din (spi_mosi),
    .dout(mosi_s),
    .rise(mosi_edges_unused[0]),
    .fall(mosi_edges_unused[1])
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        sample_tbl[i] <= DATA_W'(reset_sample(i));
      end
    end else if (ch_wr_en) begin
      sample_tbl[ch_wr_sel] <= ch_wr_data;
    end
  end

  // cs_n edges are handled before sck edges, so a coincident sck edge is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shift_in    <= '0;
      shift_out   <= '0;
      bit_cnt     <= '0;
      ch_ptr      <= '0;
      last_cmd    <= '0;
      frame_count <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            shift_out <= sample_tbl[ch_ptr];
            shift_in  <= '0;
            bit_cnt   <= '0;
            state     <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state <= IDLE;
            if (bit_cnt == BC_FULL) begin
              last_cmd    <= shift_in;
              ch_ptr      <= shift_in[CH_SEL_LSB +: CH_W];
              frame_count <= frame_count + 16'd1;
              frame_done  <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
          end else begin
            if (sck_rise) begin
              shift_in <= {shift_in[DATA_W-2:0], mosi_s};
              if (bit_cnt != BC_SAT) begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            if (sck_fall) begin
              shift_out <= {shift_out[DATA_W-2:0], 1'b0};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    spi_miso = 1'b0;
    if (state == ACTIVE) begin
      spi_miso = shift_out[DATA_W-1];
    end
  end

endmodule

// File: tb/tb_adc_spi_emulator.sv
// Scoreboard bench for adc_spi_emulator: frames push expected results, a
// monitor captures MISO bits and checks every frame_done/frame_error pulse.
module tb_adc_spi_emulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sck, spi_cs_n, spi_mosi, spi_miso;
  logic        ch_wr_en;
  logic [1:0]  ch_wr_sel;
  logic [15:0] ch_wr_data;
  logic        frame_done, frame_error;
  logic [15:0] last_cmd;
  logic [15:0] frame_count;

  adc_spi_emulator #(.DATA_W(16), .NUM_CH(4), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_sck    (spi_sck),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .ch_wr_en   (ch_wr_en),
    .ch_wr_sel  (ch_wr_sel),
    .ch_wr_data (ch_wr_data),
    .frame_done (frame_done),
    .frame_error(frame_error),
    .last_cmd   (last_cmd),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_err;
    int unsigned nbits;
    logic [31:0] miso;
    logic [15:0] count;
    logic [15:0] cmd;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_count;
  logic [15:0] m_cmd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // MISO bits seen over n SCK rises: the sample MSB-first, then zeros.
  function automatic logic [31:0] shape(input logic [15:0] sample, input int unsigned n);
    logic [31:0] w;
    w = {16'h0000, sample};
    if (n <= 16) return w >> (16 - n);
    return w << (n - 16);
  endfunction

  task automatic write_ch(input logic [1:0] sel, input logic [15:0] data);
    ch_wr_sel  = sel;
    ch_wr_data = data;
    ch_wr_en   = 1'b1;
    tick(1);
    ch_wr_en   = 1'b0;
  endtask

  task automatic frame(input logic [15:0] cmd, input int unsigned nsck, input logic [15:0] sample,
                       input int unsigned wr_bit, input logic [1:0] sel, input logic [15:0] data);
    exp_t e;
    if (nsck == 16) begin
      m_count = m_count + 16'd1;
      m_cmd   = cmd;
    end
    e.is_err = (nsck != 16);
    e.nbits  = nsck;
    e.miso   = shape(sample, nsck);
    e.count  = m_count;
    e.cmd    = m_cmd;
    sb.push_back(e);
    spi_mosi = cmd[15];
    spi_cs_n = 1'b0;
    tick(8);
    for (int i = 0; i < int'(nsck); i++) begin
      spi_mosi = (i < 16) ? cmd[15-i] : 1'b0;
      tick(8);
      spi_sck = 1'b1;
      tick(8);
      spi_sck = 1'b0;
      if (wr_bit != 0 && i == int'(wr_bit)) write_ch(sel, data);
    end
    tick(8);
    spi_cs_n = 1'b1;
    tick(16);
  endtask

  initial begin : monitor
    logic        ps;
    logic        pc;
    logic [31:0] cap;
    int unsigned nb;
    exp_t        e;
    ps  = 1'b0;
    pc  = 1'b1;
    cap = '0;
    nb  = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!spi_cs_n && pc) begin
        cap = '0;
        nb  = 0;
      end
      if (spi_sck && !ps && !spi_cs_n) begin
        cap = {cap[30:0], spi_miso};
        nb++;
      end
      ps = spi_sck;
      pc = spi_cs_n;
      if (!rst && (frame_done || frame_error)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: done=%b error=%b, no frame end expected", frame_done, frame_error);
        end else begin
          e = sb.pop_front();
          check("frame_error", 32'(frame_error), 32'(e.is_err));
          check("frame_done", 32'(frame_done), 32'(!e.is_err));
          check("miso_bits", nb, e.nbits);
          check("miso_word", cap, e.miso);
          check("frame_count", 32'(frame_count), 32'(e.count));
          check("last_cmd", 32'(last_cmd), 32'(e.cmd));
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    ch_wr_en = 1'b0; ch_wr_sel = '0; ch_wr_data = '0;
    m_count = '0; m_cmd = '0;
    tick(3);
    rst = 1'b0;
    tick(8);
    check("rst_miso", 32'(spi_miso), 32'h0);
    check("rst_done", 32'(frame_done), 32'h0);
    check("rst_error", 32'(frame_error), 32'h0);
    check("rst_last_cmd", 32'(last_cmd), 32'h0);
    check("rst_frame_count", 32'(frame_count), 32'h0);

    frame(16'h1000, 16, 16'h1234, 0, 2'd0, 16'h0);
    frame(16'h3000, 16, 16'h5678, 0, 2'd0, 16'h0);
    frame(16'h3000, 16, 16'hDEF0, 0, 2'd0, 16'h0);

    write_ch(2'd2, 16'hA5A5);
    frame(16'h2000, 16, 16'hDEF0, 0, 2'd0, 16'h0);
    frame(16'h2000, 16, 16'hA5A5, 0, 2'd0, 16'h0);
    frame(16'h0000, 16, 16'hA5A5, 5, 2'd2, 16'h0F0F);
    frame(16'h2000, 16, 16'h1234, 0, 2'd0, 16'h0);
    frame(16'h0000, 16, 16'h0F0F, 0, 2'd0, 16'h0);

    frame(16'h3000, 9, 16'h1234, 0, 2'd0, 16'h0);
    frame(16'h1000, 16, 16'h1234, 0, 2'd0, 16'h0);
    frame(16'h2000, 18, 16'h5678, 0, 2'd0, 16'h0);

    spi_mosi = 1'b1;
    spi_cs_n = 1'b0;
    tick(8);
    for (int i = 0; i < 6; i++) begin
      tick(8); spi_sck = 1'b1; tick(8); spi_sck = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("midrst_miso", 32'(spi_miso), 32'h0);
    check("midrst_frame_count", 32'(frame_count), 32'h0);
    check("midrst_last_cmd", 32'(last_cmd), 32'h0);
    tick(2);
    rst = 1'b0;
    m_count = '0;
    m_cmd   = '0;
    for (int i = 0; i < 10; i++) begin
      tick(8); spi_sck = 1'b1; tick(8); spi_sck = 1'b0;
    end
    tick(8);
    spi_cs_n = 1'b1;
    tick(16);
    check("postrst_frame_count", 32'(frame_count), 32'h0);
    check("postrst_last_cmd", 32'(last_cmd), 32'h0);

    frame(16'h2000, 16, 16'h1234, 0, 2'd0, 16'h0);
    frame(16'h0000, 16, 16'h9ABC, 0, 2'd0, 16'h0);

    force dut.frame_count = 16'hFFFF;
    tick(1);
    release dut.frame_count;
    m_count = 16'hFFFF;
    frame(16'h1000, 16, 16'h1234, 0, 2'd0, 16'h0);

    for (int i = 0; i < 200 && sb.size() != 0; i++) tick(1);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d frame ends still outstanding, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
